// File: rtl/scan_frame_buffer.sv
// scan_frame_buffer: ping-pong capture of complete revolutions, replayed over a valid/ready stream
module scan_frame_buffer #(
  parameter int POINTS = 811,
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_cycle_en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_sof,
  output logic          m_eof,
  output logic          frame_err,
  output logic [15:0]   drop_cnt,
  output logic [1:0]    banks_full
);
  typedef enum logic [1:0] {R_IDLE, R_PREP, R_SEND} rd_state_t;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(POINTS);
  localparam logic [AW:0] LAST = (AW+1)'(POINTS - 1);
  logic [DW-1:0] mem [2**(AW+1)];
  logic cyc_q, armed, ovf, wr_bank, rd_bank;
  logic rise, fall, hs, done, bank_busy, start, wr_act, wr_en, commit;
  logic [AW:0] wr_cnt, rd_ptr, wa, ra;
  rd_state_t state, state_nx;
  assign rise = in_cycle_en & ~cyc_q;
  assign fall = ~in_cycle_en & cyc_q;
  assign hs = m_valid & m_ready;
  assign done = hs & (rd_ptr == LAST);
  // a bank the reader releases this very cycle already counts as free
  assign bank_busy = banks_full[wr_bank] & ~(done & (rd_bank == wr_bank));
  assign start = rise & ~bank_busy;
  assign wa = start ? '0 : wr_cnt;
  assign wr_act = in_valid & in_cycle_en & (armed | start);
  assign wr_en = wr_act & (wa < FULL_CNT);
  assign commit = fall & armed & (wr_cnt == FULL_CNT) & ~ovf;
  assign ra = (state == R_SEND) ? (hs ? rd_ptr + 1'b1 : rd_ptr) : '0;
  assign m_valid = (state == R_SEND);
  assign m_sof = m_valid & (rd_ptr == '0);
  assign m_eof = m_valid & (rd_ptr == LAST);
  // dual-port bank RAM: writer and reader never touch the same bank at once
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wa[AW-1:0]}] <= in_data;
    m_data <= mem[{rd_bank, ra[AW-1:0]}];
  end
  // write side: window edge detection, sample counting, frame commit or discard
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= 1'b0;
      armed <= 1'b0;
      ovf <= 1'b0;
      wr_cnt <= '0;
      wr_bank <= 1'b0;
      frame_err <= 1'b0;
      drop_cnt <= '0;
      banks_full <= '0;
    end else begin
      cyc_q <= in_cycle_en;
      frame_err <= fall & armed & ~commit;
      banks_full <= (banks_full & ~(done ? 2'b01 << rd_bank : 2'b00)) | (commit ? 2'b01 << wr_bank : 2'b00);
      if (rise) begin
        armed <= start;
        ovf <= 1'b0;
        wr_cnt <= {{AW{1'b0}}, wr_en};
        if (!start && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (fall) begin
        armed <= 1'b0;
        if (commit) wr_bank <= ~wr_bank;
      end else if (wr_act) begin
        if (wr_en) wr_cnt <= wr_cnt + 1'b1;
        else ovf <= 1'b1;
      end
    end
  end
  // read side state, pointer and bank register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= R_IDLE;
      rd_bank <= 1'b0;
      rd_ptr <= '0;
    end else begin
      state <= state_nx;
      rd_ptr <= (state == R_PREP) ? '0 : rd_ptr + {{AW{1'b0}}, hs};
      if (done) rd_bank <= ~rd_bank;
    end
  end
  // read next-state: wait for a full bank, one prefetch cycle, then stream until the last word
  always_comb begin
    state_nx = state;
    state_nx = (state == R_IDLE) ? (banks_full[rd_bank] ? R_PREP : R_IDLE) :
               (state == R_PREP) ? R_SEND : (done ? R_IDLE : R_SEND);
  end
endmodule
